multicycle_control_unit: RTL

//  Sequential control unit for the multicycle RV32I core; it replaces the single-cycle decoder pair.
//  An FSM sequences fetch/decode/execute/memory/writeback over several cycles.

---
 rtl/multicycle_control_unit.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/writeback.
// Memory waits use mem_ready with a MEM_TIMEOUT cycle timeout (0 disables it).
// Optional feature: define MULDIV_EN to route op=33/funct7b0=1 through an MDU wait state.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int STATE_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  funct7b0,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  mem_ready,
  input  logic                  mdu_done,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [2:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  mdu_start,
  output logic                  illegal,
  output logic                  bus_err,
  output logic [STATE_W-1:0]    state_o
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JWB,
    S_UIMM, S_TRAP, S_MDU
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
    ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_SRA = 4'd9
  } alu_t;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait;
  logic             r_illegal;
  logic             r_bus_err;
  logic             w_set_illegal;
  logic             w_set_bus_err;
  logic             w_in_wait;
  logic             w_timeout;
  logic             w_taken;
  logic             w_mdu_start;
  alu_t             w_alu;
  alu_t             w_alu_f3;

`ifdef MULDIV_EN
  logic             r_mdu_started;
`else
  logic             w_unused_mdu_done;
  assign w_unused_mdu_done = mdu_done;
`endif

  assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait == WAIT_LAST) && !mem_ready;

  // ALU operation for R/I execute; SUB only exists for R-type.
  always_comb begin
    w_alu_f3 = ALU_ADD;
    case (funct3)
      3'b000: w_alu_f3 = (r_state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: w_alu_f3 = ALU_SLL;
      3'b010: w_alu_f3 = ALU_SLT;
      3'b011: w_alu_f3 = ALU_SLTU;
      3'b100: w_alu_f3 = ALU_XOR;
      3'b101: w_alu_f3 = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: w_alu_f3 = ALU_OR;
      default: w_alu_f3 = ALU_AND;
    endcase
  end

  // Branch condition from the ALU SUB flags.
  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000: w_taken = zero;
      3'b001: w_taken = !zero;
      3'b100: w_taken = lt;
      3'b101: w_taken = !lt;
      3'b110: w_taken = ltu;
      3'b111: w_taken = !ltu;
      default: w_taken = 1'b0;
    endcase
  end

  // Next-state and control decode for the current state.
  always_comb begin
    w_next        = r_state;
    PCWrite       = 1'b0;
    AdrSrc        = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = '0;
    ALUSrcA       = '0;
    ALUSrcB       = '0;
    ImmSrc        = '0;
    w_alu         = ALU_ADD;
    w_mdu_start   = 1'b0;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          w_next    = S_DECODE;
        end else if (w_timeout) begin
          w_next        = S_TRAP;
          w_set_bus_err = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = IMM_B;
        case (op)
          7'h03, 7'h23: w_next = S_MEMADR;
          7'h33: begin
            if (funct7b0) begin
`ifdef MULDIV_EN
              w_next = S_MDU;
`else
              w_next        = S_TRAP;
              w_set_illegal = 1'b1;
`endif
            end else begin
              w_next = S_EXECR;
            end
          end
          7'h13: w_next = S_EXECI;
          7'h63: begin
            // funct3 010/011 has no branch encoding; trap before touching the PC.
            if (funct3[2:1] == 2'b01) begin
              w_next        = S_TRAP;
              w_set_illegal = 1'b1;
            end else begin
              w_next = S_BRANCH;
            end
          end
          7'h6F: w_next = S_JAL;
          7'h67: w_next = S_JALR;
          7'h37, 7'h17: w_next = S_UIMM;
          default: begin
            w_next        = S_TRAP;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
        w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end else if (w_timeout) begin
          w_next        = S_TRAP;
          w_set_bus_err = 1'b1;
        end
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          w_next = S_FETCH;
        end else if (w_timeout) begin
          w_next        = S_TRAP;
          w_set_bus_err = 1'b1;
        end
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = 2'b01;
        w_next    = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        w_alu   = w_alu_f3;
        w_next  = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = IMM_I;
        w_alu   = w_alu_f3;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
`ifdef MULDIV_EN
        if (op == 7'h33 && funct7b0) ResultSrc = 2'b11;
`endif
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        w_alu   = ALU_SUB;
        PCWrite = w_taken;
        w_next  = S_FETCH;
      end
      // Jumps load the PC first, so JALR reads rs1 before rd can overwrite it.
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b01;
        ImmSrc    = IMM_J;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        w_next    = S_JWB;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ImmSrc    = IMM_I;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        w_next    = S_JWB;
      end
      S_JWB: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegWrite  = 1'b1;
        w_next    = S_FETCH;
      end
      S_UIMM: begin
        ALUSrcA   = op[5] ? 2'b11 : 2'b01;
        ALUSrcB   = 2'b01;
        ImmSrc    = IMM_U;
        ResultSrc = 2'b10;
        RegWrite  = 1'b1;
        w_next    = S_FETCH;
      end
`ifdef MULDIV_EN
      S_MDU: begin
        w_mdu_start = !r_mdu_started;
        if (mdu_done) w_next = S_ALUWB;
      end
`endif
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  // State register, memory wait counter and sticky fault flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_wait <= '0;
      else if (w_in_wait)    r_wait <= r_wait + CNT_W'(1);
      r_illegal <= r_illegal | w_set_illegal;
      r_bus_err <= r_bus_err | w_set_bus_err;
    end
  end

`ifdef MULDIV_EN
  // Remembers that the current MDU operation has already been started.
  always_ff @(posedge clk) begin
    if (reset) r_mdu_started <= 1'b0;
    else       r_mdu_started <= (r_state == S_MDU);
  end
`endif

  assign ALUControl = ALU_CTRL_W'(w_alu);
  assign mdu_start  = w_mdu_start;
  assign illegal    = r_illegal;
  assign bus_err    = r_bus_err;
  assign state_o    = STATE_W'(r_state);

endmodule
